// File: rtl/audio_pkg.sv
// Shared types and widths for the audio output feeder.
package audio_pkg;

  localparam int SAMPLE_W = 16;  // player sample width, two's complement
  localparam int CODEC_W  = 24;  // codec channel width

  // Drain FSM: wait for data, hold the codec strobe, one idle cycle between samples.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    GAP   = 2'd2
  } feeder_state_t;

endpackage

// File: rtl/audio_out_feeder_if.sv
// Codec-side handshake of the DE1-SoC audio core: write strobe, back-pressure, stereo data.
interface audio_out_feeder_if;
  import audio_pkg::*;

  logic               write_audio_out;
  logic               audio_out_allowed;
  logic [CODEC_W-1:0] writedata_left;
  logic [CODEC_W-1:0] writedata_right;

  // The feeder drives the strobe and data.
  modport master (
    output write_audio_out,
    output writedata_left,
    output writedata_right,
    input  audio_out_allowed
  );

  // The codec core accepts the data and reports readiness.
  modport slave (
    input  write_audio_out,
    input  writedata_left,
    input  writedata_right,
    output audio_out_allowed
  );

endinterface

// File: rtl/sample_fifo.sv
// Synchronous FIFO with wrap-bit pointers; a push at full is accepted when a pop shares the cycle.
module sample_fifo #(
  parameter  int DEPTH = 8,
  parameter  int WIDTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty,
  output logic [AW:0]      o_level
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign w_pop_ok  = i_pop && !o_empty;
  assign w_push_ok = i_push && (!o_full || w_pop_ok);

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_level = r_wr_ptr - r_rd_ptr;
  assign o_rdata = r_mem[r_rd_ptr[AW-1:0]];

  // Storage array: written on accepted pushes.
  // NOTE: the memory has no reset; empty/full come from the pointers, so stale contents are never read.
  always_ff @(posedge i_clk) begin
    if (w_push_ok) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
  end

  // Pointer update; the extra MSB distinguishes full from empty.
  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/audio_out_feeder.sv
// Buffers player samples, applies mute/attenuation at pop and feeds the codec handshake.
module audio_out_feeder
  import audio_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int LW    = $clog2(DEPTH) + 1
) (
  input  logic                CLK_50M,
  input  logic                reset,
  input  logic [SAMPLE_W-1:0] sample_in,
  input  logic                sample_valid,
  input  logic                mute,
  input  logic [2:0]          volume_shift,
  audio_out_feeder_if.master  codec,
  output logic [LW-1:0]       fifo_level,
  output logic                overflow,
  output logic [7:0]          drop_count
);

  feeder_state_t                r_state;
  feeder_state_t                w_next;
  logic                         w_pop;
  logic                         w_full;
  logic                         w_empty;
  logic                         w_drop;
  logic [SAMPLE_W-1:0]          w_rdata;
  logic signed [CODEC_W-1:0]    w_ext;
  logic signed [CODEC_W-1:0]    w_shifted;
  logic [CODEC_W-1:0]           w_scaled;
  logic                         r_write;
  logic [CODEC_W-1:0]           r_data;
  logic                         r_overflow;
  logic [7:0]                   r_drop_count;

  sample_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (SAMPLE_W)
  ) u_fifo (
    .i_clk   (CLK_50M),
    .i_rst   (reset),
    .i_push  (sample_valid),
    .i_wdata (sample_in),
    .i_pop   (w_pop),
    .o_rdata (w_rdata),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (fifo_level)
  );

  // Sample sits in the top bits of the codec word; arithmetic shift keeps the sign.
  assign w_ext     = {w_rdata, {(CODEC_W - SAMPLE_W){1'b0}}};
  assign w_shifted = w_ext >>> volume_shift;
  assign w_scaled  = mute ? '0 : w_shifted;

  // A push is lost only when full and the drain does not free a slot this cycle.
  assign w_drop = sample_valid && w_full && !w_pop;

  // FSM state register.
  always_ff @(posedge CLK_50M or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next-state and pop decision.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_next = r_state;
    w_pop  = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_empty && codec.audio_out_allowed) begin
          w_pop  = 1'b1;
          w_next = WRITE;
        end
      end
      WRITE:   if (codec.audio_out_allowed) w_next = GAP;
      GAP:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Registered codec strobe and data; data only changes on a pop so it is stable during WRITE.
  always_ff @(posedge CLK_50M or posedge reset) begin
    if (reset) begin
      r_write <= 1'b0;
      r_data  <= '0;
    end else begin
      r_write <= (w_next == WRITE);
      if (w_pop) r_data <= w_scaled;
    end
  end

  // Sticky overflow flag and saturating drop counter.
  always_ff @(posedge CLK_50M or posedge reset) begin
    if (reset) begin
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      if (r_drop_count != 8'hFF) r_drop_count <= r_drop_count + 8'd1;
    end
  end

  assign codec.write_audio_out = r_write;
  assign codec.writedata_left  = r_data;
  assign codec.writedata_right = r_data;
  assign overflow              = r_overflow;
  assign drop_count            = r_drop_count;

endmodule

// File: tb/tb_audio_out_feeder.sv
// Self-checking bench: transaction-level model compared every cycle, plus directed literal checks.
module tb_audio_out_feeder;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] sample_in = '0;
  logic        sample_valid = 1'b0;
  logic        mute = 1'b0;
  logic [2:0]  volume_shift = '0;
  logic [3:0]  fifo_level;
  logic        overflow;
  logic [7:0]  drop_count;

  int n_checks = 0;
  int n_fail   = 0;

  audio_out_feeder_if codec_if ();

  audio_out_feeder #(.DEPTH(DEPTH)) dut (
    .CLK_50M      (clk),
    .reset        (reset),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .mute         (mute),
    .volume_shift (volume_shift),
    .codec        (codec_if),
    .fifo_level   (fifo_level),
    .overflow     (overflow),
    .drop_count   (drop_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Codec word from the rules: sample * 256, arithmetic shift right, or zero when muted.
  function automatic logic [23:0] scale(input logic [15:0] s, input logic m, input logic [2:0] sh);
    int v;
    if (m) return 24'h0;
    v = int'($signed(s)) * 256;
    v = v >>> sh;
    return v[23:0];
  endfunction

  // ---------------- behavioural model ----------------
  logic [15:0] m_q [$];
  bit          m_busy;
  bit          m_gap;
  logic [23:0] m_data;
  bit          m_ovf;
  int          m_drops;

  initial begin
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        m_q.delete();
        m_busy  = 0;
        m_gap   = 0;
        m_data  = '0;
        m_ovf   = 0;
        m_drops = 0;
      end else begin
        int  sz;
        bit  popped;
        sz     = m_q.size();
        popped = 0;
        if (m_busy) begin
          if (codec_if.audio_out_allowed) begin
            m_busy = 0;
            m_gap  = 1;
          end
        end else if (m_gap) begin
          m_gap = 0;
        end else if (sz > 0 && codec_if.audio_out_allowed) begin
          m_data = scale(m_q.pop_front(), mute, volume_shift);
          m_busy = 1;
          popped = 1;
        end
        if (sample_valid) begin
          if (sz < DEPTH || popped) m_q.push_back(sample_in);
          else begin
            m_ovf = 1;
            if (m_drops < 255) m_drops++;
          end
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        check("strobe", {31'b0, codec_if.write_audio_out}, {31'b0, m_busy});
        check("left",   {8'b0, codec_if.writedata_left},  {8'b0, m_data});
        check("right",  {8'b0, codec_if.writedata_right}, {8'b0, m_data});
        check("level",  {28'b0, fifo_level}, 32'(m_q.size()));
        check("ovf",    {31'b0, overflow}, {31'b0, m_ovf});
        check("drops",  {24'b0, drop_count}, 32'(m_drops));
      end
    end
  end

  // Record every completed transfer as the codec would see it.
  logic [23:0] delivered [$];
  initial begin
    forever begin
      @(posedge clk);
      if (!reset && codec_if.write_audio_out && codec_if.audio_out_allowed)
        delivered.push_back(codec_if.writedata_left);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] s);
    sample_in    = s;
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
  endtask

  logic [23:0] held;
  logic [23:0] exp_deliv [16] = '{
    24'h123400, 24'hF00000, 24'h000000,
    24'h010100, 24'h020200, 24'h030300,
    24'h100000, 24'h100100, 24'h100200, 24'h100300,
    24'h100400, 24'h100500, 24'h100600, 24'h100700,
    24'h200000, 24'h3FFF80
  };

  initial begin
    codec_if.audio_out_allowed = 1'b0;
    tick();
    tick();
    // Reset state
    check("rst_strobe", {31'b0, codec_if.write_audio_out}, 32'h0);
    check("rst_data",   {8'b0, codec_if.writedata_left}, 32'h0);
    check("rst_level",  {28'b0, fifo_level}, 32'h0);
    check("rst_ovf",    {31'b0, overflow}, 32'h0);
    check("rst_drops",  {24'b0, drop_count}, 32'h0);
    reset = 1'b0;
    tick();

    // 1: basic transfer
    codec_if.audio_out_allowed = 1'b1;
    push(16'h1234);
    check("t1_level1", {28'b0, fifo_level}, 32'd1);
    check("t1_nostrobe", {31'b0, codec_if.write_audio_out}, 32'h0);
    tick();
    check("t1_strobe", {31'b0, codec_if.write_audio_out}, 32'h1);
    check("t1_data",   {8'b0, codec_if.writedata_left}, 32'h123400);
    check("t1_level0", {28'b0, fifo_level}, 32'd0);
    tick();
    check("t1_gap", {31'b0, codec_if.write_audio_out}, 32'h0);
    tick();
    tick();

    // 2: attenuation with sign, then mute
    volume_shift = 3'd3;
    push(16'h8000);
    tick();
    check("t2_shift", {8'b0, codec_if.writedata_left}, 32'hF00000);
    tick();
    tick();
    mute = 1'b1;
    push(16'h8000);
    tick();
    check("t2_mute", {8'b0, codec_if.writedata_right}, 32'h0);
    tick();
    tick();
    mute = 1'b0;
    volume_shift = 3'd0;

    // 3: back-pressure in IDLE and during WRITE
    codec_if.audio_out_allowed = 1'b0;
    push(16'h0101);
    push(16'h0202);
    push(16'h0303);
    tick();
    check("t3_level3", {28'b0, fifo_level}, 32'd3);
    check("t3_nostrobe", {31'b0, codec_if.write_audio_out}, 32'h0);
    codec_if.audio_out_allowed = 1'b1;
    tick();
    codec_if.audio_out_allowed = 1'b0;
    held = codec_if.writedata_left;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t3_hold_strobe", {31'b0, codec_if.write_audio_out}, 32'h1);
      check("t3_hold_data", {8'b0, codec_if.writedata_left}, {8'b0, held});
    end
    codec_if.audio_out_allowed = 1'b1;
    for (int i = 0; i < 12; i++) tick();

    // 4: overflow with 10 pushes into 8 slots
    codec_if.audio_out_allowed = 1'b0;
    for (int i = 0; i < 10; i++) push(16'h1000 + 16'(i));
    tick();
    check("t4_level", {28'b0, fifo_level}, 32'd8);
    check("t4_ovf",   {31'b0, overflow}, 32'h1);
    check("t4_drops", {24'b0, drop_count}, 32'd2);

    // 5: push at full coincident with an IDLE pop
    codec_if.audio_out_allowed = 1'b1;
    push(16'h2000);
    check("t5_level", {28'b0, fifo_level}, 32'd8);
    check("t5_drops", {24'b0, drop_count}, 32'd2);
    for (int i = 0; i < 40; i++) tick();
    check("t5_empty", {28'b0, fifo_level}, 32'd0);

    // 6: reset in the middle of WRITE
    codec_if.audio_out_allowed = 1'b0;
    push(16'h5555);
    push(16'h6666);
    codec_if.audio_out_allowed = 1'b1;
    tick();
    codec_if.audio_out_allowed = 1'b0;
    check("t6_inwrite", {31'b0, codec_if.write_audio_out}, 32'h1);
    tick();
    #2 reset = 1'b1;
    #1;
    check("t6_strobe", {31'b0, codec_if.write_audio_out}, 32'h0);
    check("t6_level",  {28'b0, fifo_level}, 32'd0);
    check("t6_ovf",    {31'b0, overflow}, 32'h0);
    check("t6_drops",  {24'b0, drop_count}, 32'd0);
    tick();
    #3 reset = 1'b0;
    tick();
    codec_if.audio_out_allowed = 1'b1;
    volume_shift = 3'd1;
    push(16'h7FFF);
    tick();
    check("t6_new", {8'b0, codec_if.writedata_left}, 32'h3FFF80);
    for (int i = 0; i < 6; i++) tick();

    // Delivery order across the whole run
    check("deliv_count", 32'(delivered.size()), 32'd16);
    for (int i = 0; i < 16; i++) begin
      if (i < delivered.size()) check("deliv", {8'b0, delivered[i]}, {8'b0, exp_deliv[i]});
      else check("deliv_missing", 32'hFFFFFFFF, {8'b0, exp_deliv[i]});
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
